// File: rtl/mem_load_store_sequencer.sv
// Core load/store sequencer in front of the SRAM controller: issues one-cycle word
// strobes, waits for the matching ack (or a timeout) and returns extended load data.
module mem_load_store_sequencer #(
  parameter int MEM_ADDR_BITS = 14,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_sync_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [2:0]               i_req_funct3,
  input  logic [31:0]              i_req_addr,
  input  logic [31:0]              i_req_wdata,
  output logic                     o_rsp_valid,
  output logic [31:0]              o_rsp_rdata,
  output logic                     o_rsp_error,
  output logic [MEM_ADDR_BITS-1:0] o_mem_addr,
  output logic                     o_mem_read_en,
  output logic [3:0]               o_mem_write_en,
  output logic [31:0]              o_mem_write_data,
  input  logic [31:0]              i_mem_read_data,
  input  logic                     i_mem_read_ack,
  input  logic                     i_mem_write_ack
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_WAIT_WR, S_RESP} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_we;
  logic [2:0]               r_f3;
  logic [1:0]               r_off;
  logic [MEM_ADDR_BITS-1:0] r_mem_addr;
  logic [31:0]              r_wdata;
  logic [3:0]               r_lanes;
  logic [31:0]              r_rdata;
  logic                     r_err;
  logic [CW-1:0]            r_cnt;

  logic                     w_accept, w_illegal, w_misal, w_bad, w_timeout;
  logic [CW-1:0]            w_cnt_inc;
  logic [3:0]               w_lanes;
  logic [31:0]              w_wdata, w_ldata;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic                     w_unused;

  assign w_unused  = ^i_req_addr[31:MEM_ADDR_BITS+2];
  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_illegal = i_req_we ? (i_req_funct3 >= 3'd3)
                              : (i_req_funct3 == 3'd3 || i_req_funct3[2:1] == 2'b11);
  assign w_misal   = (i_req_funct3[1:0] == 2'd1 && i_req_addr[0]) ||
                     (i_req_funct3[1:0] == 2'd2 && i_req_addr[1:0] != 2'd0);
  assign w_bad     = w_illegal || w_misal;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (w_cnt_inc == CW'(ACK_TIMEOUT));

  // Byte-lane strobes and lane-replicated store data
  always_comb begin
    w_lanes = 4'b1111;
    w_wdata = i_req_wdata;
    case (i_req_funct3[1:0])
      2'd0: begin
        w_lanes = 4'b0001 << i_req_addr[1:0];
        w_wdata = {4{i_req_wdata[7:0]}};
      end
      2'd1: begin
        w_lanes = 4'b0011 << {i_req_addr[1], 1'b0};
        w_wdata = {2{i_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension
  always_comb begin
    case (r_off)
      2'd0:    w_byte = i_mem_read_data[7:0];
      2'd1:    w_byte = i_mem_read_data[15:8];
      2'd2:    w_byte = i_mem_read_data[23:16];
      default: w_byte = i_mem_read_data[31:24];
    endcase
    w_half = r_off[1] ? i_mem_read_data[31:16] : i_mem_read_data[15:0];
    case (r_f3)
      3'd0:    w_ldata = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ldata = {{16{w_half[15]}}, w_half};
      3'd4:    w_ldata = {24'd0, w_byte};
      3'd5:    w_ldata = {16'd0, w_half};
      default: w_ldata = i_mem_read_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_state <= S_IDLE;
    else if (i_sync_reset) r_state <= S_IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    o_req_ready      = 1'b0;
    o_mem_read_en    = 1'b0;
    o_mem_write_en   = 4'd0;
    o_rsp_valid      = 1'b0;
    o_rsp_rdata      = 32'd0;
    o_rsp_error      = 1'b0;
    o_mem_addr       = r_mem_addr;
    o_mem_write_data = r_wdata;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (w_accept) w_state_nxt = w_bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        o_mem_read_en  = !r_we;
        o_mem_write_en = r_we ? r_lanes : 4'd0;
        w_state_nxt    = r_we ? S_WAIT_WR : S_WAIT_RD;
      end
      S_WAIT_RD: if (i_mem_read_ack || w_timeout) w_state_nxt = S_RESP;
      S_WAIT_WR: if (i_mem_write_ack || w_timeout) w_state_nxt = S_RESP;
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = r_rdata;
        o_rsp_error = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, ack capture and timeout counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we <= 1'b0; r_f3 <= 3'd0; r_off <= 2'd0; r_mem_addr <= '0;
      r_wdata <= 32'd0; r_lanes <= 4'd0; r_rdata <= 32'd0; r_err <= 1'b0; r_cnt <= '0;
    end else if (i_sync_reset) begin
      r_we <= 1'b0; r_f3 <= 3'd0; r_off <= 2'd0; r_mem_addr <= '0;
      r_wdata <= 32'd0; r_lanes <= 4'd0; r_rdata <= 32'd0; r_err <= 1'b0; r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_we       <= i_req_we;
          r_f3       <= i_req_funct3;
          r_off      <= i_req_addr[1:0];
          r_mem_addr <= i_req_addr[MEM_ADDR_BITS+1:2];
          r_wdata    <= w_wdata;
          r_lanes    <= w_lanes;
          r_rdata    <= 32'd0;
          r_err      <= w_bad;
          r_cnt      <= '0;
        end
        S_WAIT_RD: begin
          if (i_mem_read_ack) begin
            r_rdata <= w_ldata;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_WR: begin
          if (i_mem_write_ack) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
